// File: rtl/alu_share_sched_pkg.sv
// Shared types, widths and the single ALU function used by the shared-ALU scheduler.
// The opcode map lives here so the scheduler and its consumers agree on encodings.
package alu_share_sched_pkg;

    localparam int N   = 8;
    localparam int OPN = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam logic [OPN-1:0] OP_ADD = 3'd0;
    localparam logic [OPN-1:0] OP_SUB = 3'd1;
    localparam logic [OPN-1:0] OP_AND = 3'd2;
    localparam logic [OPN-1:0] OP_OR  = 3'd3;
    localparam logic [OPN-1:0] OP_XOR = 3'd4;
    localparam logic [OPN-1:0] OP_SHL = 3'd5;
    localparam logic [OPN-1:0] OP_SHR = 3'd6;
    localparam logic [OPN-1:0] OP_PSB = 3'd7;

    // Results are truncated to N bits; shifts use the low three bits of y.
    function automatic logic [N-1:0] alu(
        input logic [OPN-1:0] op,
        input logic [N-1:0]   x,
        input logic [N-1:0]   y
    );
        logic [N-1:0] r;
        r = {N{1'b0}};
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SHL:  r = x << y[2:0];
            OP_SHR:  r = x >> y[2:0];
            OP_PSB:  r = y;
            default: r = y;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_share_sched_rsp_buf.sv
// One-entry valid/ready holding register for a requester's result.
// A write may coincide with the consumer draining the old value.
module alu_rsp_buf
    import alu_share_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr,
    input  logic [N-1:0] i_wr_data,
    input  logic         i_rsp_ready,
    output logic         o_can_accept,
    output logic         o_rsp_valid,
    output logic [N-1:0] o_z
);

    logic         r_valid;
    logic [N-1:0] r_z;

    assign o_can_accept = ~r_valid | i_rsp_ready;
    assign o_rsp_valid  = r_valid;
    assign o_z          = r_z;

    // Hold the result until taken; a write wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_z     <= {N{1'b0}};
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_z     <= i_wr_data;
        end else if (i_rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_share_sched.sv
// Two requesters share one ALU; each job is z = alu(op2, alu(op1,a,b), c) over two passes.
// Round-robin arbitration, one job in flight, per-requester one-entry result buffers.
module alu_share_sched
    import alu_share_sched_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid_0,
    input  logic           req_valid_1,
    output logic           req_ready_0,
    output logic           req_ready_1,
    input  logic [N-1:0]   a_0,
    input  logic [N-1:0]   b_0,
    input  logic [N-1:0]   c_0,
    input  logic [N-1:0]   a_1,
    input  logic [N-1:0]   b_1,
    input  logic [N-1:0]   c_1,
    input  logic [OPN-1:0] op1_0,
    input  logic [OPN-1:0] op2_0,
    input  logic [OPN-1:0] op1_1,
    input  logic [OPN-1:0] op2_1,
    output logic           rsp_valid_0,
    output logic           rsp_valid_1,
    input  logic           rsp_ready_0,
    input  logic           rsp_ready_1,
    output logic [N-1:0]   z_0,
    output logic [N-1:0]   z_1,
    output logic           busy
);

    state_t         r_state;
    logic           r_last;
    logic           r_busy;
    logic           r_id;
    logic [OPN-1:0] r_op1;
    logic [OPN-1:0] r_op2;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_c;
    logic [N-1:0]   r_q;

    logic [OPN-1:0] w_alu_op;
    logic [N-1:0]   w_alu_x;
    logic [N-1:0]   w_alu_y;
    logic [N-1:0]   w_alu_z;
    logic [N-1:0]   w_wdata;
    logic           w_acc0;
    logic           w_acc1;
    logic           w_write;
    logic           w_window;
    logic           w_pick;
    logic           w_grant_any;

    // Single ALU call site: pass 1 uses (a,b), every other state uses (q,c) with op2.
    always_comb begin
        w_alu_op = r_op2;
        w_alu_x  = r_q;
        w_alu_y  = r_c;
        if (r_state == S_P1) begin
            w_alu_op = r_op1;
            w_alu_x  = r_a;
            w_alu_y  = r_b;
        end else begin
            w_alu_op = r_op2;
            w_alu_x  = r_q;
            w_alu_y  = r_c;
        end
        w_alu_z = alu(w_alu_op, w_alu_x, w_alu_y);
    end

    // Result write and arbitration; a grant shares the cycle with a result write.
    always_comb begin
        w_wdata  = (r_state == S_WAIT) ? r_q : w_alu_z;
        w_write  = ((r_state == S_P2) || (r_state == S_WAIT)) && (r_id ? w_acc1 : w_acc0);
        w_window = rst && ((r_state == S_IDLE) || w_write);
        if (req_valid_0 && req_valid_1) begin
            w_pick = ~r_last;
        end else begin
            w_pick = req_valid_1;
        end
        w_grant_any = w_window && (req_valid_0 || req_valid_1);
    end

    assign req_ready_0 = w_grant_any & ~w_pick;
    assign req_ready_1 = w_grant_any &  w_pick;
    assign busy        = r_busy;

    // Scheduler FSM, round-robin pointer and captured job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_busy  <= 1'b0;
            r_id    <= 1'b0;
            r_op1   <= {OPN{1'b0}};
            r_op2   <= {OPN{1'b0}};
            r_a     <= {N{1'b0}};
            r_b     <= {N{1'b0}};
            r_c     <= {N{1'b0}};
            r_q     <= {N{1'b0}};
        end else begin
            if (w_grant_any) begin
                r_last <= w_pick;
                r_id   <= w_pick;
                r_op1  <= w_pick ? op1_1 : op1_0;
                r_op2  <= w_pick ? op2_1 : op2_0;
                r_a    <= w_pick ? a_1 : a_0;
                r_b    <= w_pick ? b_1 : b_0;
                r_c    <= w_pick ? c_1 : c_0;
            end
            case (r_state)
                S_IDLE: begin
                    r_state <= w_grant_any ? S_P1 : S_IDLE;
                    r_busy  <= w_grant_any;
                end
                S_P1: begin
                    r_q     <= w_alu_z;
                    r_state <= S_P2;
                    r_busy  <= 1'b1;
                end
                S_P2, S_WAIT: begin
                    if (w_write) begin
                        r_state <= w_grant_any ? S_P1 : S_IDLE;
                        r_busy  <= w_grant_any;
                    end else begin
                        // Park the finished result until the buffer frees up.
                        r_q     <= w_wdata;
                        r_state <= S_WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    alu_rsp_buf u_buf0 (
        .clk          (clk),
        .rst_n        (rst),
        .i_wr         (w_write & ~r_id),
        .i_wr_data    (w_wdata),
        .i_rsp_ready  (rsp_ready_0),
        .o_can_accept (w_acc0),
        .o_rsp_valid  (rsp_valid_0),
        .o_z          (z_0)
    );

    alu_rsp_buf u_buf1 (
        .clk          (clk),
        .rst_n        (rst),
        .i_wr         (w_write & r_id),
        .i_wr_data    (w_wdata),
        .i_rsp_ready  (rsp_ready_1),
        .o_can_accept (w_acc1),
        .o_rsp_valid  (rsp_valid_1),
        .o_z          (z_1)
    );

endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench for alu_share_sched: directed latency/backpressure cases plus random traffic.
module tb_alu_share_sched;
    import alu_share_sched_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [N-1:0]   a_0, b_0, c_0, a_1, b_1, c_1;
    logic [OPN-1:0] op1_0, op2_0, op1_1, op2_1;
    logic           rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
    logic [N-1:0]   z_0, z_1;
    logic           busy;

    always #5 clk = ~clk;

    alu_share_sched dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .a_0(a_0), .b_0(b_0), .c_0(c_0), .a_1(a_1), .b_1(b_1), .c_1(c_1),
        .op1_0(op1_0), .op2_0(op2_0), .op1_1(op1_1), .op2_1(op2_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .z_0(z_0), .z_1(z_1), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: byte arithmetic on plain integers.
    function automatic int ref_alu(input int op, input int x, input int y);
        case (op)
            0: return (x + y) % 256;
            1: return (x - y + 256) % 256;
            2: return x & y;
            3: return x | y;
            4: return x ^ y;
            5: return (x * (1 << (y % 8))) % 256;
            6: return x / (1 << (y % 8));
            default: return y;
        endcase
    endfunction

    function automatic int ref_job(input int op1, input int a, input int b, input int op2, input int c);
        return ref_alu(op2, ref_alu(op1, a, b), c);
    endfunction

    // Monitor / scoreboard
    int   exp_q0[$];
    int   exp_q1[$];
    logic tb_last = 1'b1;
    logic hold0 = 1'b0, hold1 = 1'b0;
    logic [N-1:0] hz0, hz1;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q0.delete();
            exp_q1.delete();
            tb_last = 1'b1;
            hold0   = 1'b0;
            hold1   = 1'b0;
        end else begin
            if (req_ready_0 || req_ready_1)
                check_eq("one_grant", {31'd0, req_ready_0 & req_ready_1}, 32'd0);
            if (req_valid_0 && req_valid_1 && (req_ready_0 || req_ready_1))
                check_eq("rr_order", {31'd0, req_ready_1}, {31'd0, ~tb_last});
            if (req_valid_0 && req_ready_0) begin
                exp_q0.push_back(ref_job(op1_0, a_0, b_0, op2_0, c_0));
                tb_last = 1'b0;
            end
            if (req_valid_1 && req_ready_1) begin
                exp_q1.push_back(ref_job(op1_1, a_1, b_1, op2_1, c_1));
                tb_last = 1'b1;
            end
            if (hold0) begin
                check_eq("hold_valid0", {31'd0, rsp_valid_0}, 32'd1);
                check_eq("hold_z0", {24'd0, z_0}, {24'd0, hz0});
            end
            if (hold1) begin
                check_eq("hold_valid1", {31'd0, rsp_valid_1}, 32'd1);
                check_eq("hold_z1", {24'd0, z_1}, {24'd0, hz1});
            end
            if (rsp_valid_0 && rsp_ready_0) begin
                check_eq("rsp0_expected", {31'd0, exp_q0.size() > 0}, 32'd1);
                if (exp_q0.size() > 0) check_eq("z0_value", {24'd0, z_0}, exp_q0.pop_front());
            end
            if (rsp_valid_1 && rsp_ready_1) begin
                check_eq("rsp1_expected", {31'd0, exp_q1.size() > 0}, 32'd1);
                if (exp_q1.size() > 0) check_eq("z1_value", {24'd0, z_1}, exp_q1.pop_front());
            end
            hold0 = rsp_valid_0 && !rsp_ready_0;
            hold1 = rsp_valid_1 && !rsp_ready_1;
            hz0   = z_0;
            hz1   = z_1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input int a, input int b, input int c, input int o1, input int o2);
        a_0 = a[N-1:0]; b_0 = b[N-1:0]; c_0 = c[N-1:0];
        op1_0 = o1[OPN-1:0]; op2_0 = o2[OPN-1:0];
    endtask

    task automatic drive1(input int a, input int b, input int c, input int o1, input int o2);
        a_1 = a[N-1:0]; b_1 = b[N-1:0]; c_1 = c[N-1:0];
        op1_1 = o1[OPN-1:0]; op2_1 = o2[OPN-1:0];
    endtask

    task automatic rand_ops();
        drive0($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 7), $urandom_range(0, 7));
        drive1($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 7), $urandom_range(0, 7));
    endtask

    // Lone job on requester 0 from IDLE with a free buffer: checks grant, stall and t+3 latency.
    task automatic single_job0(input int a, input int b, input int c, input int o1, input int o2);
        int exp_z;
        exp_z = ref_job(o1, a, b, o2, c);
        step();
        drive0(a, b, c, o1, o2);
        req_valid_0 = 1'b1;
        @(negedge clk) check_eq("single_grant", {31'd0, req_ready_0}, 32'd1);
        step();
        @(negedge clk) check_eq("single_p1_ready", {31'd0, req_ready_0}, 32'd0);
        check_eq("single_busy", {31'd0, busy}, 32'd1);
        step();
        req_valid_0 = 1'b0;
        @(negedge clk) check_eq("single_early_rsp", {31'd0, rsp_valid_0}, 32'd0);
        step();
        @(negedge clk) check_eq("single_lat_rsp", {31'd0, rsp_valid_0}, 32'd1);
        check_eq("single_z", {24'd0, z_0}, exp_z);
    endtask

    int g0;
    int zA, zB;

    initial begin
        rst = 1'b1;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_ready0", {31'd0, req_ready_0}, 32'd0);
        check_eq("rst_rsp_valid0", {31'd0, rsp_valid_0}, 32'd0);
        check_eq("rst_z0", {24'd0, z_0}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // Basic single jobs, including 8-bit wraparound.
        single_job0(3, 4, 5, 0, 0);
        single_job0(8'hFF, 8'h01, 0, 0, 0);
        single_job0(5, 9, 8'h0F, 1, 4);
        step();

        // Contention: both valid every cycle, alternate grants every two cycles.
        g0 = tb_last ? 0 : 1;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        rand_ops();
        for (int o = 0; o < 8; o++) begin
            @(negedge clk);
            if (o % 2 == 0) begin
                check_eq("cont_grant_id", {31'd0, req_ready_1}, g0 ^ ((o / 2) % 2));
                check_eq("cont_grant_any", {31'd0, req_ready_0 | req_ready_1}, 32'd1);
            end else begin
                check_eq("cont_no_grant", {31'd0, req_ready_0 | req_ready_1}, 32'd0);
                if (o >= 3)
                    check_eq("cont_rsp_lat",
                             {31'd0, ((g0 ^ (((o - 3) / 2) % 2)) != 0) ? rsp_valid_1 : rsp_valid_0}, 32'd1);
            end
            step();
            rand_ops();
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        repeat (5) step();

        // Backpressure: requester 0 buffer full forces WAIT and starves requester 1.
        zA = ref_job(0, 10, 20, 1, 3);
        zB = ref_job(2, 8'h0F, 8'h33, 3, 8'h40);
        rsp_ready_0 = 1'b0;
        drive0(10, 20, 3, 0, 1);
        req_valid_0 = 1'b1;
        @(negedge clk) check_eq("bp_grant_a", {31'd0, req_ready_0}, 32'd1);
        step();
        drive0(8'h0F, 8'h33, 8'h40, 2, 3);
        step();
        @(negedge clk) check_eq("bp_grant_b", {31'd0, req_ready_0}, 32'd1);
        step();
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b1;
        drive1(1, 2, 3, 0, 0);
        @(negedge clk) check_eq("bp_z_a", {24'd0, z_0}, zA);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check_eq("bp_no_grant1", {31'd0, req_ready_1}, 32'd0);
            check_eq("bp_busy", {31'd0, busy}, 32'd1);
        end
        step();
        rsp_ready_0 = 1'b1;
        @(negedge clk) check_eq("bp_release_grant1", {31'd0, req_ready_1}, 32'd1);
        step();
        req_valid_1 = 1'b0;
        @(negedge clk) check_eq("bp_valid_b", {31'd0, rsp_valid_0}, 32'd1);
        check_eq("bp_z_b", {24'd0, z_0}, zB);
        repeat (5) step();

        // Drain + fill: buffer 0 taken in the same cycle it is rewritten.
        zA = ref_job(4, 8'hAA, 8'h0F, 0, 1);
        zB = ref_job(5, 3, 2, 6, 1);
        rsp_ready_0 = 1'b0;
        drive0(8'hAA, 8'h0F, 1, 4, 0);
        req_valid_0 = 1'b1;
        step();
        drive0(3, 2, 1, 5, 6);
        step();
        @(negedge clk) check_eq("df_grant_b", {31'd0, req_ready_0}, 32'd1);
        step();
        req_valid_0 = 1'b0;
        @(negedge clk) check_eq("df_z_a", {24'd0, z_0}, zA);
        step();
        rsp_ready_0 = 1'b1;
        @(negedge clk) check_eq("df_valid_mid", {31'd0, rsp_valid_0}, 32'd1);
        step();
        @(negedge clk) check_eq("df_valid_b", {31'd0, rsp_valid_0}, 32'd1);
        check_eq("df_z_b", {24'd0, z_0}, zB);
        step();
        @(negedge clk) check_eq("df_empty", {31'd0, rsp_valid_0}, 32'd0);
        step();

        // Reset in the middle of pass 2: outputs clear at once, the job never answers.
        drive0(7, 7, 7, 0, 0);
        req_valid_0 = 1'b1;
        step();
        req_valid_0 = 1'b0;
        step();
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_ready0", {31'd0, req_ready_0}, 32'd0);
        check_eq("mid_rst_ready1", {31'd0, req_ready_1}, 32'd0);
        check_eq("mid_rst_valid0", {31'd0, rsp_valid_0}, 32'd0);
        check_eq("mid_rst_valid1", {31'd0, rsp_valid_1}, 32'd0);
        check_eq("mid_rst_z0", {24'd0, z_0}, 32'd0);
        check_eq("mid_rst_z1", {24'd0, z_1}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        step();
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("post_rst_no_rsp", {31'd0, rsp_valid_0 | rsp_valid_1}, 32'd0);
            check_eq("post_rst_idle", {31'd0, busy}, 32'd0);
            step();
        end

        // Random traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            req_valid_0 = ($urandom_range(0, 9) < 7);
            req_valid_1 = ($urandom_range(0, 9) < 7);
            rsp_ready_0 = ($urandom_range(0, 9) < 7);
            rsp_ready_1 = ($urandom_range(0, 9) < 7);
            rand_ops();
            step();
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        for (int k = 0; k < 30 && (exp_q0.size() + exp_q1.size()) > 0; k++) step();
        repeat (2) step();
        check_eq("drain_q0", exp_q0.size(), 32'd0);
        check_eq("drain_q1", exp_q1.size(), 32'd0);
        check_eq("drain_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
